// File: rtl/nvm_burst_reader.sv
// Burst reader: fetches consecutive NVM words and streams each one out bit-serially
// over a valid/ready link, with wait-state tolerant reads and sink backpressure.
module nvm_burst_reader #(
  parameter  int DATA_W    = 8,
  parameter  int ADDR_W    = 8,
  parameter  int MAX_BURST = 16,
  parameter  int LSB_FIRST = 0,
  localparam int LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [LEN_W-1:0]  burst_len_i,
  output logic              busy_o,
  output logic              nvm_rd_o,
  output logic [ADDR_W-1:0] nvm_addr_o,
  input  logic              nvm_valid_i,
  input  logic [DATA_W-1:0] nvm_data_i,
  output logic              ser_out_o,
  output logic              ser_valid_o,
  input  logic              ser_ready_i,
  output logic              ser_last_o,
  output logic              burst_last_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SHIFT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

  logic [LEN_W-1:0]   len_clamped;
  logic               word_end;

  assign len_clamped = (burst_len_i > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : burst_len_i;
  assign word_end    = (bit_cnt_q == CNT_W'(DATA_W - 1));

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned (no latches).
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d    = start_addr_i;
          len_d     = len_clamped;
          bit_cnt_d = '0;
          state_d   = (len_clamped == '0) ? S_DONE : S_REQ;
        end
      end

      S_REQ: begin
        if (nvm_valid_i) begin
          shreg_d   = nvm_data_i;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (ser_ready_i) begin
          if (LSB_FIRST != 0) shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
          else                shreg_d = {shreg_q[DATA_W-2:0], 1'b0};

          if (word_end) begin
            bit_cnt_d = '0;
            len_d     = len_q - LEN_W'(1);
            // Another word is pending: re-arm the read at the next (wrapping) address.
            if (len_q > LEN_W'(1)) begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = S_REQ;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // All outputs decode registered state, so they are glitch-free and zero out of reset.
  assign busy_o       = (state_q != S_IDLE);
  assign nvm_rd_o     = (state_q == S_REQ);
  assign nvm_addr_o   = addr_q;
  assign ser_valid_o  = (state_q == S_SHIFT);
  assign ser_out_o    = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[DATA_W-1];
  assign ser_last_o   = (state_q == S_SHIFT) && word_end;
  assign burst_last_o = ser_last_o && (len_q == LEN_W'(1));
  assign done_o       = (state_q == S_DONE);

endmodule

// File: tb/tb_nvm_burst_reader.sv
// Scoreboard bench for nvm_burst_reader: an MSB-first and an LSB-first instance share
// stimulus; each has its own wait-state memory model and its own expected-bit queue.
module tb_nvm_burst_reader;

  localparam int DW = 8;
  localparam int MAXB = 16;

  typedef struct packed {
    logic b;
    logic last;
    logic blast;
  } bit_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] start_addr;
  logic [4:0] burst_len;
  logic       ser_ready;

  logic [1:0] busy, nvm_rd, nvm_valid, ser_out, ser_valid, ser_last, burst_last, done;
  logic [7:0] nvm_addr [2];
  logic [7:0] nvm_data [2];

  logic [7:0] mem [256];
  int         wait_cycles = 0;
  bit         rdy_mode = 1'b0;

  bit_t       bq0[$], bq1[$];
  logic [7:0] aq0[$], aq1[$];

  int n_vec = 0, n_fail = 0;
  int exp_reads = 0, exp_done = 0;
  int reads [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int xfer_cnt [2] = '{0, 0};
  int rd_cyc [2] = '{0, 0};
  bit hold [2] = '{0, 0};
  logic [2:0] held [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    int wcnt;

    nvm_burst_reader #(
      .DATA_W(DW), .ADDR_W(8), .MAX_BURST(MAXB), .LSB_FIRST(g)
    ) u_dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .start_addr_i(start_addr),
      .burst_len_i(burst_len), .busy_o(busy[g]), .nvm_rd_o(nvm_rd[g]),
      .nvm_addr_o(nvm_addr[g]), .nvm_valid_i(nvm_valid[g]), .nvm_data_i(nvm_data[g]),
      .ser_out_o(ser_out[g]), .ser_valid_o(ser_valid[g]), .ser_ready_i(ser_ready),
      .ser_last_o(ser_last[g]), .burst_last_o(burst_last[g]), .done_o(done[g])
    );

    // Memory answers after wait_cycles extra cycles; data bus carries junk otherwise.
    assign nvm_valid[g] = nvm_rd[g] && (wcnt >= wait_cycles);
    assign nvm_data[g]  = nvm_valid[g] ? mem[nvm_addr[g]] : 8'hE7;

    always @(posedge clk) begin
      if (rst || !nvm_rd[g] || nvm_valid[g]) wcnt <= 0;
      else                                   wcnt <= wcnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready driver: constant 1, or the repeating 1,0,0,1 pattern.
  initial begin
    logic [3:0] pat;
    int pidx;
    pat = 4'b1001;
    pidx = 0;
    ser_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode) begin
        ser_ready = pat[pidx];
        pidx = (pidx + 1) % 4;
      end else begin
        ser_ready = 1'b1;
      end
    end
  end

  // Monitor: pops expectations whenever a DUT presents a bit or completes a read.
  initial begin
    bit_t e;
    logic [2:0] cur;
    logic [7:0] ea;
    bit avail;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int g = 0; g < 2; g++) begin
          hold[g] = 1'b0;
          rd_cyc[g] = 0;
        end
      end else begin
        for (int g = 0; g < 2; g++) begin
          if (ser_valid[g]) begin
            cur = {ser_out[g], ser_last[g], burst_last[g]};
            if (hold[g]) check($sformatf("stall_hold%0d", g), 32'(cur), 32'(held[g]));
            if (ser_ready) begin
              avail = (g == 0) ? (bq0.size() != 0) : (bq1.size() != 0);
              check($sformatf("bit_expected%0d", g), 32'(avail), 1);
              if (avail) begin
                if (g == 0) e = bq0.pop_front();
                else        e = bq1.pop_front();
                check($sformatf("ser_bit%0d_xfer%0d", g, xfer_cnt[g]), 32'(cur), 32'(e));
              end
              hold[g] = 1'b0;
              xfer_cnt[g]++;
            end else begin
              hold[g] = 1'b1;
              held[g] = cur;
            end
          end else begin
            if (hold[g]) check($sformatf("stall_valid%0d", g), 32'(ser_valid[g]), 1);
            hold[g] = 1'b0;
          end

          if (nvm_rd[g]) begin
            rd_cyc[g]++;
            if (nvm_valid[g]) begin
              avail = (g == 0) ? (aq0.size() != 0) : (aq1.size() != 0);
              check($sformatf("read_expected%0d", g), 32'(avail), 1);
              if (avail) begin
                if (g == 0) ea = aq0.pop_front();
                else        ea = aq1.pop_front();
                check($sformatf("nvm_addr%0d", g), 32'(nvm_addr[g]), 32'(ea));
              end
              check($sformatf("rd_hold_cycles%0d", g), rd_cyc[g], wait_cycles + 1);
              rd_cyc[g] = 0;
              reads[g]++;
            end
          end

          if (done[g]) done_cnt[g]++;
        end
      end
    end
  end

  task automatic push_expect(input logic [7:0] addr, input int eff);
    logic [7:0] a, w;
    bit_t e0, e1;
    for (int i = 0; i < eff; i++) begin
      a = addr + 8'(i);
      w = mem[a];
      aq0.push_back(a);
      aq1.push_back(a);
      for (int j = 0; j < DW; j++) begin
        e0.b     = w[DW-1-j];
        e1.b     = w[j];
        e0.last  = (j == DW - 1);
        e0.blast = (j == DW - 1) && (i == eff - 1);
        e1.last  = e0.last;
        e1.blast = e0.blast;
        bq0.push_back(e0);
        bq1.push_back(e1);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_outs%0d", tag, g),
            32'({busy[g], nvm_rd[g], ser_out[g], ser_valid[g], ser_last[g], burst_last[g], done[g]}), 0);
      check($sformatf("%s_addr%0d", tag, g), 32'(nvm_addr[g]), 0);
    end
  endtask

  // Issues one burst; returns in the first IDLE cycle after done, with start low.
  task automatic run_burst(input logic [7:0] addr, input int len_req, input int waitc, input bit hold_start);
    int eff, cyc;
    bit found;
    eff = (len_req > MAXB) ? MAXB : len_req;
    push_expect(addr, eff);
    exp_reads += eff;
    exp_done++;
    wait_cycles = waitc;
    start = 1'b1;
    start_addr = addr;
    burst_len = 5'(len_req);
    @(posedge clk); #1;
    start = hold_start;
    start_addr = 8'hC7;
    burst_len = 5'd7;
    for (int g = 0; g < 2; g++) begin
      if (eff == 0) begin
        check($sformatf("len0_done%0d", g), 32'({done[g], nvm_rd[g]}), 32'(2'b10));
      end else begin
        check($sformatf("first_rd%0d", g), 32'(nvm_rd[g]), 1);
        check($sformatf("first_addr%0d", g), 32'(nvm_addr[g]), 32'(addr));
      end
    end
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < 2000) begin
      @(negedge clk);
      if (done[0]) found = 1'b1;
      else cyc++;
    end
    if (!rdy_mode) check("done_latency", cyc, eff * (waitc + DW + 1));
    else           check("done_seen", 32'(found), 1);
    check("done_lsb_lockstep", 32'(done[1]), 1);
    check("busy_in_done", 32'(busy[0]), 1);
    @(posedge clk); #1;
    start = 1'b0;
    for (int g = 0; g < 2; g++)
      check($sformatf("idle_after_done%0d", g), 32'({busy[g], done[g]}), 0);
  endtask

  initial begin
    int base, cyc, dbase;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[8'h10] = 8'hA5;
    mem[8'h20] = 8'h5A;
    mem[8'h21] = 8'hC3;
    mem[8'h22] = 8'h0F;
    mem[8'hFF] = 8'h81;
    mem[8'h00] = 8'h7E;
    mem[8'h40] = 8'h01;
    mem[8'h30] = 8'h96;
    mem[8'h31] = 8'h3B;

    rst = 1'b1;
    start = 1'b0;
    start_addr = 8'h00;
    burst_len = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_burst(8'h10, 1, 0, 1'b0);        // single word 0xA5, no waits
    run_burst(8'h20, 3, 2, 1'b0);        // three words, two wait states each
    rdy_mode = 1'b1;
    run_burst(8'h10, 1, 0, 1'b0);        // backpressure pattern 1,0,0,1
    rdy_mode = 1'b0;
    @(posedge clk); #1;
    run_burst(8'hFF, 2, 0, 1'b0);        // address wrap 0xFF -> 0x00
    run_burst(8'h33, 0, 0, 1'b0);        // zero-length burst
    run_burst(8'h50, MAXB + 5, 0, 1'b0); // clamped to MAX_BURST words
    run_burst(8'h40, 1, 1, 1'b0);        // 0x01 exposes bit order
    run_burst(8'h21, 2, 1, 1'b1);        // start held high through the whole burst

    // Reset during the 4th bit of word 2, with start held high as well.
    push_expect(8'h30, 3);
    exp_reads += 2;
    wait_cycles = 0;
    base = xfer_cnt[0];
    start = 1'b1;
    start_addr = 8'h30;
    burst_len = 5'd3;
    @(posedge clk); #1;
    start_addr = 8'h99;
    cyc = 0;
    while (xfer_cnt[0] != base + 11 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reach_bit11", xfer_cnt[0] - base, 11);
    @(posedge clk); #1;
    check("rst_mid_word_valid", 32'(ser_valid[0]), 1);
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midrst");
    bq0.delete();
    bq1.delete();
    aq0.delete();
    aq1.delete();
    dbase = done_cnt[0];
    repeat (12) @(negedge clk);
    check("no_done_after_rst", done_cnt[0], dbase);
    @(posedge clk); #1;
    run_burst(8'h10, 1, 0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("reads_total%0d", g), reads[g], exp_reads);
      check($sformatf("done_total%0d", g), done_cnt[g], exp_done);
    end
    check("bits_left0", bq0.size(), 0);
    check("bits_left1", bq1.size(), 0);
    check("addrs_left", aq0.size() + aq1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

endmodule
